// File: rtl/timer_unit_pkg.sv
// Shared constants for the memory-mapped interval timer.
// Address map and reset values are kept here so the top, the counter and the bench agree.
package timer_unit_pkg;

    localparam int TIMER_WORD_W = 32;

    localparam logic [TIMER_WORD_W-1:0] CYCLE_ADDR      = 32'hFFFF_001C;
    localparam logic [TIMER_WORD_W-1:0] ACK_ADDR        = 32'hFFFF_006C;
    localparam logic [TIMER_WORD_W-1:0] IRQ_CYCLE_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/timer_unit_if.sv
// MEM-stage access bus between the pipeline and the timer.
// Handshake: none; a load or store is valid in the cycle MemRead/MemWrite is 1 and is always accepted.
interface timer_unit_if;
    import timer_unit_pkg::*;

    logic [TIMER_WORD_W-1:0] address;
    logic [TIMER_WORD_W-1:0] data;
    logic                    MemRead;
    logic                    MemWrite;
    logic [TIMER_WORD_W-1:0] cycle;
    logic                    TimerAddress;
    logic                    TimerInterrupt;

    modport master (
        output address, data, MemRead, MemWrite,
        input  cycle, TimerAddress, TimerInterrupt
    );

    modport slave (
        input  address, data, MemRead, MemWrite,
        output cycle, TimerAddress, TimerInterrupt
    );

endinterface

// File: rtl/timer_unit_counter32.sv
// Enabled incrementing register with asynchronous active-low clear.
// Wraps modulo 2^TIMER_WORD_W silently.
module counter32
    import timer_unit_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    output logic [TIMER_WORD_W-1:0] count
);

    logic [TIMER_WORD_W-1:0] count_q;
    logic [TIMER_WORD_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = count_q + TIMER_WORD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/timer_unit.sv
// Interval timer beside data memory: free-running cycle counter, compare register,
// and a sticky interrupt request to cp0 cleared by a store to the ack address.
module timer_unit
    import timer_unit_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    timer_unit_if.slave  bus
);

    logic [TIMER_WORD_W-1:0] cycle_count;
    logic [TIMER_WORD_W-1:0] irq_cycle_q;
    logic [TIMER_WORD_W-1:0] irq_cycle_d;
    logic                    irq_line_q;
    logic                    irq_line_d;
    logic                    hit_cycle;
    logic                    hit_ack;
    logic                    match;

    counter32 u_cycle_count (
        .clk   (clock),
        .rst_n (reset),
        .en    (1'b1),
        .count (cycle_count)
    );

    assign hit_cycle = (bus.address == CYCLE_ADDR);
    assign hit_ack   = (bus.address == ACK_ADDR);
    // Compare uses the pre-edge registers, so a compare write never matches in its own cycle.
    assign match     = (cycle_count == irq_cycle_q);

    always_comb begin
        irq_cycle_d = irq_cycle_q;
        irq_line_d  = irq_line_q;
        if (bus.MemWrite && hit_cycle) begin
            irq_cycle_d = bus.data;
        end
        // Set has priority over ack so a fresh match is never lost.
        if (match) begin
            irq_line_d = 1'b1;
        end else if (bus.MemWrite && hit_ack) begin
            irq_line_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irq_cycle_q <= IRQ_CYCLE_RESET;
            irq_line_q  <= 1'b0;
        end else begin
            irq_cycle_q <= irq_cycle_d;
            irq_line_q  <= irq_line_d;
        end
    end

    assign bus.cycle          = (bus.MemRead && hit_cycle) ? cycle_count : '0;
    assign bus.TimerAddress   = hit_cycle | hit_ack;
    assign bus.TimerInterrupt = irq_line_q;

endmodule

// File: tb/tb_timer_unit.sv
// Self-checking bench for timer_unit: directed scenarios plus random MEM-stage traffic
// compared every cycle against a behavioural model of the timer.
module tb_timer_unit;
    import timer_unit_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    timer_unit_if bus ();

    timer_unit dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural model: counter, compare value and pending flag
    logic [31:0] m_count;
    logic [31:0] m_irq_cycle;
    logic        m_irq;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count     = 32'd0;
            m_irq_cycle = IRQ_CYCLE_RESET;
            m_irq       = 1'b0;
        end else begin
            logic hit_now;
            hit_now = (m_count == m_irq_cycle);
            if (bus.MemWrite && bus.address == ACK_ADDR) m_irq = 1'b0;
            if (hit_now) m_irq = 1'b1;
            if (bus.MemWrite && bus.address == CYCLE_ADDR) m_irq_cycle = bus.data;
            m_count = m_count + 32'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // driver: present one access, check combinational and registered outputs, advance a cycle
    task automatic cycle_op(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] dat);
        bus.MemRead  = rd;
        bus.MemWrite = wr;
        bus.address  = addr;
        bus.data     = dat;
        #1;
        check("cycle", bus.cycle, (rd && addr == CYCLE_ADDR) ? m_count : 32'd0);
        check("taddr", {31'b0, bus.TimerAddress}, {31'b0, (addr == CYCLE_ADDR || addr == ACK_ADDR)});
        check("irq", {31'b0, bus.TimerInterrupt}, {31'b0, m_irq});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle_op(1'b0, 1'b0, 32'h0000_0000, 32'h0);
    endtask

    task automatic peek_count(input string tag, input logic [31:0] exp);
        bus.MemRead  = 1'b1;
        bus.MemWrite = 1'b0;
        bus.address  = CYCLE_ADDR;
        #1;
        check(tag, bus.cycle, exp);
        bus.MemRead  = 1'b0;
        bus.address  = 32'h0;
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.MemRead  = 1'b1;
        bus.MemWrite = 1'b0;
        bus.address  = CYCLE_ADDR;
        bus.data     = 32'h0;
        #1;
        check("rst_irq", {31'b0, bus.TimerInterrupt}, 32'd0);
        check("rst_cycle", bus.cycle, 32'd0);
        check("rst_taddr", {31'b0, bus.TimerAddress}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // compare store at count 3, then read at count 5
        idle(3);
        cycle_op(1'b0, 1'b1, CYCLE_ADDR, 32'd20);
        idle(1);
        peek_count("count5", 32'd5);
        cycle_op(1'b1, 1'b0, CYCLE_ADDR, 32'h0);
        for (int i = 0; i < 200 && m_count != 32'd32; i++) idle(1);
        check("irq_sticky", {31'b0, bus.TimerInterrupt}, 32'd1);

        // ack clears on next edge; ack address reads back 0
        cycle_op(1'b1, 1'b1, ACK_ADDR, $urandom);
        check("ack_clear", {31'b0, bus.TimerInterrupt}, 32'd0);
        cycle_op(1'b1, 1'b0, ACK_ADDR, 32'h0);

        // foreign address is not decoded
        cycle_op(1'b1, 1'b0, 32'h1001_0000, 32'h0);

        // ack in the exact match cycle: set wins
        cycle_op(1'b0, 1'b1, CYCLE_ADDR, 32'd40);
        begin
            int waited;
            waited = 0;
            while (m_count != 32'd40 && waited < 200) begin
                idle(1);
                waited++;
            end
            if (waited >= 200) begin
                total++;
                bad++;
                $display("FAIL wait40: count never reached 40 (got %h)", m_count);
            end
        end
        cycle_op(1'b0, 1'b1, ACK_ADDR, 32'hDEAD_BEEF);
        check("set_wins", {31'b0, bus.TimerInterrupt}, 32'd1);

        // random MEM-stage traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] addr;
            logic [31:0] dat;
            case ($urandom_range(0, 4))
                0, 1: addr = CYCLE_ADDR;
                2:    addr = ACK_ADDR;
                3:    addr = CYCLE_ADDR + 32'd4;
                default: addr = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0, 1: dat = m_count + 32'($urandom_range(1, 20));
                2:    dat = m_count;
                default: dat = $urandom;
            endcase
            cycle_op(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), addr, dat);
        end

        // wrap: counter forced near the top, compare at 1
        cycle_op(1'b0, 1'b1, CYCLE_ADDR, 32'd1);
        cycle_op(1'b0, 1'b1, ACK_ADDR, 32'd0);
        force dut.u_cycle_count.count_q = 32'hFFFF_FFFD;
        m_count = 32'hFFFF_FFFD;
        #1;
        release dut.u_cycle_count.count_q;
        idle(3);
        check("wrap_no_irq", {31'b0, bus.TimerInterrupt}, 32'd0);
        peek_count("wrap_zero", 32'd0);
        idle(2);
        peek_count("wrap_two", 32'd2);
        check("wrap_irq", {31'b0, bus.TimerInterrupt}, 32'd1);
        idle(2);

        // async reset mid-cycle with an interrupt pending
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_irq", {31'b0, bus.TimerInterrupt}, 32'd0);
        peek_count("async_rst_cnt", 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        peek_count("restart", 32'd3);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // hard stop in case something above stalls
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1, "timeout");
    end

endmodule
